sec_clear_ctrl: RTL and testbench

SEC_CLEAR_CTRL -- requirements
Module: sec_clear_ctrl

---
 rtl/sec_clear_ctrl.sv | 129 ++++++++++++
 tb/tb_sec_clear_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sec_clear_ctrl.sv
// Secure clear sequencer: zeroes a masked set of registers (CLRREG) or a
// word-aligned memory range (CLRMEM), stalling the pipeline while it works.
module sec_clear_ctrl #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_clrreg,
    input  logic        start_clrmem,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_REG = 2'd1,
        CLR_MEM = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_mask,  w_mask_nxt;
    logic [4:0]         r_idx,   w_idx_nxt;
    logic [31:0]        r_addr,  w_addr_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               r_err,   w_err_nxt;

    assign rf_wdata  = 32'd0;
    assign mem_wdata = 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mask  <= 32'd0;
            r_idx   <= 5'd0;
            r_addr  <= 32'd0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_idx   <= w_idx_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        rf_we       = 1'b0;
        rf_waddr    = 5'd0;
        mem_req     = 1'b0;
        mem_addr    = 32'd0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (r_state)
            IDLE: begin
                // CLRREG has priority when both starts arrive together
                if (start_clrreg) begin
                    w_mask_nxt  = rs1_val & ~32'd1;
                    w_idx_nxt   = 5'd1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = CLR_REG;
                end else if (start_clrmem) begin
                    w_addr_nxt = rs1_val;
                    w_err_nxt  = 1'b0;
                    w_cnt_nxt  = '0;
                    if ((rs1_val[1:0] != 2'b00) || (rs2_val > 32'(MAX_WORDS))) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = FINISH;
                    end else if (rs2_val == 32'd0) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_cnt_nxt   = rs2_val[CNT_W-1:0];
                        w_state_nxt = CLR_MEM;
                    end
                end
            end
            CLR_REG: begin
                busy      = 1'b1;
                rf_we     = r_mask[r_idx];
                rf_waddr  = r_idx;
                w_idx_nxt = r_idx + 5'd1;
                if (r_idx == 5'd31) begin
                    w_state_nxt = FINISH;
                end
            end
            CLR_MEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (mem_ready) begin
                    w_addr_nxt = r_addr + 32'd4;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                done        = 1'b1;
                err         = r_err;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sec_clear_ctrl.sv
// Scoreboard bench for sec_clear_ctrl: stimulus queues expected writes and
// done pulses; a negedge monitor pops and compares them as the DUT emits them.
module tb_sec_clear_ctrl;

    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_clrreg = 1'b0;
    logic        start_clrmem = 1'b0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic        mem_ready = 1'b1;
    logic        rf_we, mem_req, busy, done, err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, mem_addr, mem_wdata;

    sec_clear_ctrl #(.MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .start_clrreg(start_clrreg), .start_clrmem(start_clrmem),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 = rf write, 1 = mem write, 2 = done
        logic [31:0] val;    // register index, address, or err flag
    } ev_t;

    ev_t sbq[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic sb_check(input int kind, input logic [31:0] val, input string nm);
        ev_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected event actual=%h expected=none", nm, val);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_fail++;
                $display("FAIL %s actual kind=%0d val=%h expected kind=%0d val=%h",
                         nm, kind, val, e.kind, e.val);
            end
        end
    endtask

    // Monitor: samples mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_we) begin
                sb_check(0, {27'd0, rf_waddr}, "rf_write");
                chk("rf_wdata_zero", rf_wdata, 32'd0);
            end
            if (mem_req && mem_ready) begin
                sb_check(1, mem_addr, "mem_write");
                chk("mem_wdata_zero", mem_wdata, 32'd0);
            end
            if (done) begin
                sb_check(2, {31'd0, err}, "done_err");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_reg(input logic [31:0] mask);
        start_clrreg = 1'b1;
        rs1_val      = mask;
        tick();
        start_clrreg = 1'b0;
        rs1_val      = 32'hDEAD_BEEF;
    endtask

    task automatic issue_mem(input logic [31:0] base, input logic [31:0] len);
        start_clrmem = 1'b1;
        rs1_val      = base;
        rs2_val      = len;
        tick();
        start_clrmem = 1'b0;
        rs1_val      = 32'hDEAD_BEEF;
        rs2_val      = 32'hFFFF_FFFF;
    endtask

    // Wait for done, counting busy cycles; optionally pulse both starts while busy
    // and optionally pulse a start during the FINISH cycle.
    task automatic wait_done(input string nm, input int exp_busy, input int inject_at,
                             input bit finish_start);
        int  busy_n;
        bit  seen;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            start_clrreg = (inject_at > 0) && (busy_n == inject_at) && busy;
            start_clrmem = start_clrreg;
            rs1_val      = start_clrreg ? 32'hFFFF_FFFF : 32'h0;
            rs2_val      = start_clrreg ? 32'd1 : 32'h0;
            tick();
        end
        start_clrreg = 1'b0;
        start_clrmem = 1'b0;
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout waiting for done actual=none expected=done", nm);
        end else begin
            chk({nm, "_busy_cycles"}, busy_n, exp_busy);
            chk({nm, "_busy_in_finish"}, {31'd0, busy}, 32'd0);
            if (finish_start) begin
                start_clrreg = 1'b1;
                rs1_val      = 32'hFFFF_FFFF;
            end
            tick();
            start_clrreg = 1'b0;
            chk({nm, "_finish_one_cycle"}, {30'd0, done, busy}, 32'd0);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_outputs", {busy, done, err, rf_we, mem_req, rf_waddr},  32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // CLRREG 0xF1 with starts injected while busy and during FINISH
        push(0, 32'd4); push(0, 32'd5); push(0, 32'd6); push(0, 32'd7); push(2, 32'd0);
        issue_reg(32'h0000_00F1);
        wait_done("clrreg_f1", 31, 5, 1'b1);

        // CLRMEM base 0x1000, len 3, stall two cycles on the second word
        push(1, 32'h1000); push(1, 32'h1004); push(1, 32'h1008); push(2, 32'd0);
        mem_ready = 1'b1;
        issue_mem(32'h1000, 32'd3);
        chk("mem_first_addr", mem_addr, 32'h1000);
        tick();
        mem_ready = 1'b0;
        chk("stall_addr0", mem_addr, 32'h1004);
        tick();
        chk("stall_addr1", {31'd0, mem_req} ^ 32'h0 | (mem_addr == 32'h1004 ? 32'd0 : 32'd2), 32'd1);
        tick();
        chk("stall_addr2", mem_addr, 32'h1004);
        mem_ready = 1'b1;
        wait_done("clrmem_stall", 2, 0, 1'b0);

        // Rejections: misaligned base, length above MAX_WORDS
        push(2, 32'd1);
        issue_mem(32'h1002, 32'd1);
        chk("rej_align_now", {29'd0, done, err, mem_req}, 32'b110);
        wait_done("rej_align", 0, 0, 1'b0);
        push(2, 32'd1);
        issue_mem(32'h1000, 32'(MW + 1));
        chk("rej_len_now", {29'd0, done, err, mem_req}, 32'b110);
        wait_done("rej_len", 0, 0, 1'b0);

        // Zero length: immediate done with no error
        push(2, 32'd0);
        issue_mem(32'h4000, 32'd0);
        chk("len0_now", {29'd0, done, err, mem_req}, 32'b100);
        wait_done("len0", 0, 0, 1'b0);

        // Maximum length accepted
        for (int i = 0; i < MW; i++) push(1, 32'h2000 + 32'(4 * i));
        push(2, 32'd0);
        issue_mem(32'h2000, 32'(MW));
        wait_done("len_max", MW, 0, 1'b0);

        // Simultaneous starts: CLRREG wins; mask bit 0 ignored
        push(0, 32'd1); push(2, 32'd0);
        start_clrmem = 1'b1;
        rs2_val      = 32'd2;
        issue_reg(32'h0000_0003);
        chk("both_start_no_mem", {31'd0, mem_req}, 32'd0);
        wait_done("both_start", 31, 0, 1'b0);

        // Address wrap
        push(1, 32'hFFFF_FFFC); push(1, 32'h0000_0000); push(2, 32'd0);
        issue_mem(32'hFFFF_FFFC, 32'd2);
        wait_done("wrap", 2, 0, 1'b0);

        // Reset after one of four words
        push(1, 32'h3000);
        issue_mem(32'h3000, 32'd4);
        tick();
        mem_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        mem_ready = 1'b1;
        chk("midrst_outputs", {busy, done, err, rf_we, mem_req, rf_waddr}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        tick();
        tick();
        chk("midrst_stays_idle", {30'd0, busy, done}, 32'd0);

        push(0, 32'd31); push(2, 32'd0);
        issue_reg(32'h8000_0000);
        wait_done("after_rst_clrreg", 31, 0, 1'b0);

        tick();
        tick();
        chk("sb_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
